// File: rtl/mips32_pkg.sv
// Shared opcodes, field positions, instruction classes and pipeline register
// layouts for the 5-stage MIPS32-subset core.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam int OP_HI = 31, OP_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int IMM_HI = 15, IMM_LO = 0;

  // Unassigned opcode, decodes as NOP; used for squashed/injected slots.
  localparam logic [31:0] IR_NOP = 32'hC000_0000;

  // NOP is the all-zero class so a cleared pipeline register is a bubble.
  typedef enum logic [2:0] {
    NOP = 3'd0, RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT
  } itype_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } if_id_t;

  typedef struct packed {
    itype_e      t;
    logic [5:0]  op;
    logic [31:0] npc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
  } id_ex_t;

  typedef struct packed {
    itype_e      t;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  dst;
  } ex_mem_t;

  typedef struct packed {
    itype_e      t;
    logic [31:0] res;
    logic [4:0]  dst;
  } mem_wb_t;

  localparam if_id_t IF_ID_NOP = '{ir: IR_NOP, npc: 32'd0};

  function automatic itype_e decode(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BNEQZ, OP_BEQZ:                             return BRANCH;
      OP_HLT:                                        return HALT;
      default:                                       return NOP;
    endcase
  endfunction

  function automatic logic wr_reg(input itype_e t);
    return (t == RR_ALU) || (t == RM_ALU) || (t == LOAD);
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational ALU keyed directly by opcode; loads, stores and anything
// unrecognised fall through to an add (address generation).
module mips32_alu (
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  import mips32_pkg::*;

  always_comb begin
    case (op)
      OP_SUB, OP_SUBI: result = a - b;
      OP_AND:          result = a & b;
      OP_OR:           result = a | b;
      OP_SLT, OP_SLTI: result = {31'd0, $signed(a) < $signed(b)};
      OP_MUL:          result = a * b;
      default:         result = a + b;
    endcase
  end

endmodule

// File: rtl/pipelined_mips32.sv
// 5-stage in-order MIPS32-subset core with internal memories, full ALU
// forwarding, EX-resolved branches and a freeze-on-HLT fetch unit.
module pipelined_mips32 #(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic clk1,
  input  logic rst_n,
  output logic halted
);
  import mips32_pkg::*;

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [31:0] regbank   [0:31];
  logic [31:0] instr_mem [0:IMEM_DEPTH-1];
  logic [31:0] data_mem  [0:DMEM_DEPTH-1];

  logic [31:0] PC;
  logic        HALTED, TAKEN_BRANCH;
  logic        halt_pend;

  if_id_t  if_id;
  id_ex_t  id_ex,  id_ex_d;
  ex_mem_t ex_mem, ex_mem_d;
  mem_wb_t mem_wb, mem_wb_d;

  logic        wb_we, mem_we, ex_fwd, wb_fwd, br_taken;
  logic [31:0] fa, fb, alu_b, alu_res, br_target, ld_data;
  itype_e      id_t;

  assign halted = HALTED;

  // Writeback; a reset edge aborts whatever is retiring.
  assign wb_we  = rst_n && !HALTED && wr_reg(mem_wb.t);
  assign mem_we = rst_n && !HALTED && (ex_mem.t == STORE);

  // ID: decode and register read with WB write-through.
  assign id_t = decode(if_id.ir[OP_HI:OP_LO]);

  always_comb begin
    id_ex_d     = '0;
    id_ex_d.t   = id_t;
    id_ex_d.op  = if_id.ir[OP_HI:OP_LO];
    id_ex_d.npc = if_id.npc;
    id_ex_d.rs  = if_id.ir[RS_HI:RS_LO];
    id_ex_d.rt  = if_id.ir[RT_HI:RT_LO];
    id_ex_d.dst = (id_t == RR_ALU) ? if_id.ir[RD_HI:RD_LO] : if_id.ir[RT_HI:RT_LO];
    id_ex_d.imm = {{16{if_id.ir[IMM_HI]}}, if_id.ir[IMM_HI:IMM_LO]};
    id_ex_d.a   = (wb_we && mem_wb.dst == id_ex_d.rs) ? mem_wb.res : regbank[id_ex_d.rs];
    id_ex_d.b   = (wb_we && mem_wb.dst == id_ex_d.rt) ? mem_wb.res : regbank[id_ex_d.rt];
  end

  // EX: load results are not yet available from EX/MEM, only ALU results.
  assign ex_fwd = (ex_mem.t == RR_ALU) || (ex_mem.t == RM_ALU);
  assign wb_fwd = wr_reg(mem_wb.t);

  always_comb begin
    fa = id_ex.a;
    if (ex_fwd && ex_mem.dst == id_ex.rs)      fa = ex_mem.alu;
    else if (wb_fwd && mem_wb.dst == id_ex.rs) fa = mem_wb.res;
    fb = id_ex.b;
    if (ex_fwd && ex_mem.dst == id_ex.rt)      fb = ex_mem.alu;
    else if (wb_fwd && mem_wb.dst == id_ex.rt) fb = mem_wb.res;
  end

  assign alu_b = (id_ex.t == RR_ALU) ? fb : id_ex.imm;

  mips32_alu u_alu (.op(id_ex.op), .a(fa), .b(alu_b), .result(alu_res));

  assign br_taken  = (id_ex.t == BRANCH) && ((id_ex.op == OP_BEQZ) == (fa == 32'd0));
  assign br_target = id_ex.npc + id_ex.imm;

  always_comb begin
    ex_mem_d     = '0;
    ex_mem_d.t   = id_ex.t;
    ex_mem_d.alu = alu_res;
    ex_mem_d.b   = fb;
    ex_mem_d.dst = id_ex.dst;
  end

  // MEM
  assign ld_data = data_mem[ex_mem.alu[DAW-1:0]];

  always_comb begin
    mem_wb_d     = '0;
    mem_wb_d.t   = ex_mem.t;
    mem_wb_d.res = (ex_mem.t == LOAD) ? ld_data : ex_mem.alu;
    mem_wb_d.dst = ex_mem.dst;
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      halt_pend    <= 1'b0;
      if_id        <= IF_ID_NOP;
      id_ex        <= '0;
      ex_mem       <= '0;
      mem_wb       <= '0;
    end else begin
      TAKEN_BRANCH <= br_taken;
      if (br_taken) begin
        PC    <= br_target;
        if_id <= IF_ID_NOP;
        id_ex <= '0;
      end else begin
        // Once HLT is seen in ID, fetch stays frozen until reset.
        if (halt_pend || id_t == HALT) begin
          halt_pend <= 1'b1;
          if_id     <= IF_ID_NOP;
        end else begin
          PC    <= PC + 32'd1;
          if_id <= '{ir: instr_mem[PC[IAW-1:0]], npc: PC + 32'd1};
        end
        id_ex <= id_ex_d;
      end
      ex_mem <= ex_mem_d;
      mem_wb <= mem_wb_d;
      if (ex_mem.t == HALT) HALTED <= 1'b1;
    end
  end

  // Architectural storage is not reset.
  always_ff @(posedge clk1) begin
    if (wb_we)  regbank[mem_wb.dst]           <= mem_wb.res;
    if (mem_we) data_mem[ex_mem.alu[DAW-1:0]] <= ex_mem.b;
  end

endmodule

// File: tb/tb_pipelined_mips32.sv
// Program-level bench: preloads memories, runs each program to HLT and
// compares architectural state against a queue of expected results.
module tb_pipelined_mips32;
  import mips32_pkg::*;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  logic halted;
  int   n_chk = 0, n_fail = 0, taken_cnt = 0;

  pipelined_mips32 #(.IMEM_DEPTH(1024), .DMEM_DEPTH(1024)) dut (
    .clk1(clk1), .rst_n(rst_n), .halted(halted)
  );

  always #5 clk1 = ~clk1;

  typedef struct { string nm; bit is_mem; int idx; logic [31:0] exp; } exp_t;
  typedef struct { string nm; logic [5:0] op; bit is_imm; logic [31:0] a, b, exp; } vec_t;
  exp_t sb[$];
  vec_t vt[14];

  localparam logic [31:0] HLTW = {OP_HLT, 26'd0};

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_reg(input string nm, input int idx, input logic [31:0] v);
    sb.push_back('{nm, 1'b0, idx, v});
  endtask

  task automatic exp_mem(input string nm, input int idx, input logic [31:0] v);
    sb.push_back('{nm, 1'b1, idx, v});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.nm, e.is_mem ? dut.data_mem[e.idx] : dut.regbank[e.idx], e.exp);
    end
  endtask

  // Hold reset, then clear memories and set regbank[i]=i.
  task automatic begin_test();
    rst_n = 1'b0;
    @(negedge clk1);
    @(negedge clk1);
    for (int i = 0; i < 1024; i++) begin
      dut.instr_mem[i] = IR_NOP;
      dut.data_mem[i]  = 32'd0;
    end
    for (int i = 0; i < 32; i++) dut.regbank[i] = i;
  endtask

  task automatic run(input string nm, input int budget, output int cyc);
    rst_n = 1'b1;
    cyc = 0;
    taken_cnt = 0;
    while (!halted && cyc < budget) begin
      @(negedge clk1);
      cyc++;
      if (dut.TAKEN_BRANCH) taken_cnt++;
    end
    check({nm, "_halted"}, 32'(halted), 32'd1);
  endtask

  task automatic load_ls();
    dut.data_mem[120] = 32'd85;
    dut.instr_mem[0] = ri(OP_ADDI, 1, 0, 120);
    dut.instr_mem[1] = rr(OP_OR, 3, 3, 3);
    dut.instr_mem[2] = ri(OP_LW, 2, 1, 0);
    dut.instr_mem[3] = rr(OP_OR, 3, 3, 3);
    dut.instr_mem[4] = ri(OP_ADDI, 2, 2, 45);
    dut.instr_mem[5] = rr(OP_OR, 3, 3, 3);
    dut.instr_mem[6] = ri(OP_SW, 2, 1, 1);
    dut.instr_mem[7] = HLTW;
  endtask

  task automatic exp_ls();
    exp_mem("ls_m121", 121, 32'd130);
    exp_mem("ls_m120", 120, 32'd85);
    exp_reg("ls_r1", 1, 32'd120);
    exp_reg("ls_r2", 2, 32'd130);
    exp_reg("ls_r3", 3, 32'd3);
  endtask

  initial begin
    int cyc, stuck;

    vt[0]  = '{"slt_neg",   OP_SLT,  1'b0, 32'hFFFF_FFFF, 32'd0,         32'd1};
    vt[1]  = '{"slt_pos",   OP_SLT,  1'b0, 32'd0,         32'hFFFF_FFFF, 32'd0};
    vt[2]  = '{"addi_wrap", OP_ADDI, 1'b1, 32'hFFFF_FFFF, 32'd1,         32'd0};
    vt[3]  = '{"mul_ovf",   OP_MUL,  1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0};
    vt[4]  = '{"mul_small", OP_MUL,  1'b0, 32'd7,         32'd6,         32'd42};
    vt[5]  = '{"mul_neg",   OP_MUL,  1'b0, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD};
    vt[6]  = '{"add_ovf",   OP_ADD,  1'b0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000};
    vt[7]  = '{"sub_wrap",  OP_SUB,  1'b0, 32'd0,         32'd1,         32'hFFFF_FFFF};
    vt[8]  = '{"and",       OP_AND,  1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0};
    vt[9]  = '{"or",        OP_OR,   1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0};
    vt[10] = '{"slti_f",    OP_SLTI, 1'b1, 32'd5,         32'h0000_FFFF, 32'd0};
    vt[11] = '{"slti_t",    OP_SLTI, 1'b1, 32'hFFFF_FFFE, 32'h0000_FFFF, 32'd1};
    vt[12] = '{"subi_neg",  OP_SUBI, 1'b1, 32'd10,        32'h0000_FFFE, 32'd12};
    vt[13] = '{"nop_op",    6'b010101, 1'b0, 32'd9,       32'd4,         32'd3};

    // Reset state
    begin_test();
    check("rst_pc", dut.PC, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_taken", 32'(dut.TAKEN_BRANCH), 32'd0);

    // Load/use with gap instructions, then store
    begin_test();
    load_ls();
    exp_ls();
    run("ls", 100, cyc);
    check("ls_latency", cyc, 32'd11);
    check("ls_pc_frozen", dut.PC, 32'd8);
    drain();

    // Back-to-back ALU hazards through EX/MEM
    begin_test();
    dut.instr_mem[0] = rr(OP_ADD, 5, 1, 2);
    dut.instr_mem[1] = rr(OP_MUL, 6, 5, 4);
    dut.instr_mem[2] = rr(OP_SUB, 7, 6, 1);
    dut.instr_mem[3] = HLTW;
    exp_reg("hz_r5", 5, 32'd3);
    exp_reg("hz_r6", 6, 32'd12);
    exp_reg("hz_r7", 7, 32'd11);
    run("hz", 100, cyc);
    check("hz_latency", cyc, 32'd7);
    drain();

    // Branch loop; R13 counts executions of the slot after the branch
    begin_test();
    dut.regbank[11] = 32'd0;
    dut.regbank[13] = 32'd0;
    dut.instr_mem[0] = ri(OP_ADDI, 10, 0, 3);
    dut.instr_mem[1] = ri(OP_SUBI, 10, 10, 1);
    dut.instr_mem[2] = ri(OP_ADDI, 11, 11, 2);
    dut.instr_mem[3] = ri(OP_BNEQZ, 0, 10, -3);
    dut.instr_mem[4] = ri(OP_ADDI, 13, 13, 1);
    dut.instr_mem[5] = ri(OP_ADDI, 12, 0, 7);
    dut.instr_mem[6] = HLTW;
    exp_reg("br_r10", 10, 32'd0);
    exp_reg("br_r11", 11, 32'd6);
    exp_reg("br_r12", 12, 32'd7);
    exp_reg("br_r13", 13, 32'd1);
    run("br", 300, cyc);
    check("br_taken_pulses", taken_cnt, 32'd2);
    drain();

    // BEQZ: not-taken then taken, skipping one instruction
    begin_test();
    dut.instr_mem[0] = ri(OP_BEQZ, 0, 1, 5);
    dut.instr_mem[1] = ri(OP_BEQZ, 0, 0, 1);
    dut.instr_mem[2] = ri(OP_ADDI, 21, 0, 5);
    dut.instr_mem[3] = ri(OP_ADDI, 22, 0, 6);
    dut.instr_mem[4] = HLTW;
    exp_reg("bz_r21", 21, 32'd21);
    exp_reg("bz_r22", 22, 32'd6);
    run("bz", 100, cyc);
    check("bz_taken_pulses", taken_cnt, 32'd1);
    drain();

    // Arithmetic table: op R3,R1,R2 (or op R3,R1,imm) ; HLT
    for (int i = 0; i < 14; i++) begin
      begin_test();
      dut.regbank[1] = vt[i].a;
      dut.regbank[2] = vt[i].b;
      dut.instr_mem[0] = vt[i].is_imm ? ri(vt[i].op, 3, 1, int'(vt[i].b)) : rr(vt[i].op, 3, 1, 2);
      dut.instr_mem[1] = HLTW;
      exp_reg(vt[i].nm, 3, vt[i].exp);
      run(vt[i].nm, 50, cyc);
      drain();
    end

    // Nothing after HLT may write; halted is sticky and PC frozen
    begin_test();
    dut.instr_mem[0] = ri(OP_ADDI, 21, 0, 5);
    dut.instr_mem[1] = HLTW;
    dut.instr_mem[2] = ri(OP_ADDI, 20, 0, 99);
    dut.instr_mem[3] = ri(OP_SW, 20, 0, 50);
    exp_reg("hl_r21", 21, 32'd5);
    exp_reg("hl_r20", 20, 32'd20);
    exp_mem("hl_m50", 50, 32'd0);
    run("hl", 100, cyc);
    stuck = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk1);
      if (!halted) stuck++;
    end
    check("hl_sticky", stuck, 32'd0);
    check("hl_pc_frozen", dut.PC, 32'd2);
    drain();

    // Mid-run reset aborts and reruns from address 0
    begin_test();
    load_ls();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk1);
    rst_n = 1'b0;
    @(negedge clk1);
    @(negedge clk1);
    check("mr_pc", dut.PC, 32'd0);
    check("mr_halted", 32'(halted), 32'd0);
    exp_ls();
    run("mr", 100, cyc);
    check("mr_latency", cyc, 32'd11);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
